// File: rtl/core_types_pkg.sv
// ============================================================================
// Module      : core_types_pkg
// Description : Shared core types and sizes for the branch checkpoint logic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package core_types_pkg;

    localparam int CHECKPOINT_COLUMNS     = 4;
    localparam int LOG_CHECKPOINT_COLUMNS = 2;
    localparam int LOG_ROB_DEPTH          = 5;

    typedef logic [LOG_CHECKPOINT_COLUMNS-1:0] checkpoint_column_t;
    typedef logic [LOG_ROB_DEPTH-1:0]          ROB_index_t;
    typedef logic [LOG_CHECKPOINT_COLUMNS:0]   checkpoint_count_t;

    typedef enum logic [1:0] {
        CKPT_FREE     = 2'd0,
        CKPT_ACTIVE   = 2'd1,
        CKPT_RESOLVED = 2'd2
    } checkpoint_state_t;

endpackage

`default_nettype wire

// File: rtl/checkpoint_younger_mask.sv
// ============================================================================
// Module      : checkpoint_younger_mask
// Description : Circular mask of columns from start_column up to (not incl.)
//               tail_column. start == tail means the whole ring is squashed.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module checkpoint_younger_mask
    import core_types_pkg::*;
(
    input  logic [LOG_CHECKPOINT_COLUMNS-1:0] start_column,
    input  logic [LOG_CHECKPOINT_COLUMNS-1:0] tail_column,
    output logic [CHECKPOINT_COLUMNS-1:0]     squash_mask
);

    localparam checkpoint_count_t c_full_span = checkpoint_count_t'(CHECKPOINT_COLUMNS);

    checkpoint_column_t w_span;
    checkpoint_count_t  w_span_ext;

    // An ACTIVE start equal to tail can only happen when the ring is full,
    // so a zero distance stands for "every column".
    assign w_span     = tail_column - start_column;
    assign w_span_ext = (w_span == '0) ? c_full_span : {1'b0, w_span};

    genvar gi;
    generate
        for (gi = 0; gi < CHECKPOINT_COLUMNS; gi++) begin : g_mask
            checkpoint_column_t w_offset;
            assign w_offset        = checkpoint_column_t'(gi) - start_column;
            assign squash_mask[gi] = ({1'b0, w_offset} < w_span_ext);
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/checkpoint_ctrl.sv
// ============================================================================
// Module      : checkpoint_ctrl
// Description : Allocates, retires and squashes branch checkpoint columns as a
//               circular queue. Option macro: CHECKPOINT_CTRL_RETIRE_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module checkpoint_ctrl
    import core_types_pkg::*;
(
    input  logic                              CLK,
    input  logic                              nRST,
    input  logic                              save_req_valid,
    input  logic [LOG_ROB_DEPTH-1:0]          save_req_ROB_index,
    output logic                              save_req_ready,
    output logic                              save_en,
    output logic [LOG_CHECKPOINT_COLUMNS-1:0] save_column,
    input  logic                              resolve_valid,
    input  logic [LOG_CHECKPOINT_COLUMNS-1:0] resolve_column,
    input  logic                              resolve_mispredict,
    output logic                              restore_en,
    output logic [LOG_CHECKPOINT_COLUMNS-1:0] restore_column,
    output logic [LOG_ROB_DEPTH-1:0]          restore_ROB_index,
    input  logic                              flush,
    output logic [LOG_CHECKPOINT_COLUMNS:0]   active_count
);

    checkpoint_state_t  r_state [CHECKPOINT_COLUMNS];
    ROB_index_t         r_rob_index [CHECKPOINT_COLUMNS];
    checkpoint_column_t r_head;
    checkpoint_column_t r_tail;
    checkpoint_count_t  r_active_count;

    checkpoint_state_t  w_state_next [CHECKPOINT_COLUMNS];
    ROB_index_t         w_rob_index_next [CHECKPOINT_COLUMNS];
    checkpoint_column_t w_head_next;
    checkpoint_column_t w_tail_next;
    checkpoint_count_t  w_count_next;

    logic w_resolve_active;
    logic w_mispredict;
    logic w_correct;
    logic w_retire;
    logic w_bypass;
    logic [CHECKPOINT_COLUMNS-1:0] w_squash_mask;

    assign w_resolve_active = resolve_valid && (r_state[resolve_column] == CKPT_ACTIVE);
    assign w_mispredict     = w_resolve_active && resolve_mispredict;
    assign w_correct        = w_resolve_active && !resolve_mispredict;
    assign w_retire         = (r_state[r_head] == CKPT_RESOLVED);

`ifdef CHECKPOINT_CTRL_RETIRE_BYPASS_EN
    // Full ring whose oldest column is retiring: hand that column straight over.
    assign w_bypass = w_retire && (r_head == r_tail);
`else
    assign w_bypass = 1'b0;
`endif

    assign restore_en        = w_mispredict && !flush;
    assign restore_column    = restore_en ? resolve_column : '0;
    assign restore_ROB_index = restore_en ? r_rob_index[resolve_column] : '0;

    assign save_req_ready = ((r_state[r_tail] == CKPT_FREE) || w_bypass) && !flush && !restore_en;
    assign save_en        = save_req_valid && save_req_ready;
    assign save_column    = r_tail;
    assign active_count   = r_active_count;

    checkpoint_younger_mask u_younger_mask (
        .start_column (resolve_column),
        .tail_column  (r_tail),
        .squash_mask  (w_squash_mask)
    );

    always_comb begin
        w_state_next     = r_state;
        w_rob_index_next = r_rob_index;
        w_head_next      = r_head;
        w_tail_next      = r_tail;
        w_count_next     = '0;

        if (flush) begin
            for (int i = 0; i < CHECKPOINT_COLUMNS; i++) begin
                w_state_next[i] = CKPT_FREE;
            end
            w_head_next = '0;
            w_tail_next = '0;
        end else if (restore_en) begin
            for (int i = 0; i < CHECKPOINT_COLUMNS; i++) begin
                if (w_squash_mask[i]) begin
                    w_state_next[i] = CKPT_FREE;
                end
            end
            w_tail_next = resolve_column;
            // A RESOLVED head is always older than the mispredicted column.
            if (w_retire) begin
                w_state_next[r_head] = CKPT_FREE;
                w_head_next          = r_head + 1'b1;
            end
        end else begin
            if (w_correct) begin
                w_state_next[resolve_column] = CKPT_RESOLVED;
            end
            if (w_retire) begin
                w_state_next[r_head] = CKPT_FREE;
                w_head_next          = r_head + 1'b1;
            end
            // Last so a bypassed head column ends up ACTIVE rather than FREE.
            if (save_en) begin
                w_state_next[r_tail]     = CKPT_ACTIVE;
                w_rob_index_next[r_tail] = save_req_ROB_index;
                w_tail_next              = r_tail + 1'b1;
            end
        end

        for (int i = 0; i < CHECKPOINT_COLUMNS; i++) begin
            if (w_state_next[i] != CKPT_FREE) begin
                w_count_next = w_count_next + checkpoint_count_t'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            for (int i = 0; i < CHECKPOINT_COLUMNS; i++) begin
                r_state[i]     <= CKPT_FREE;
                r_rob_index[i] <= '0;
            end
            r_head         <= '0;
            r_tail         <= '0;
            r_active_count <= '0;
        end else begin
            for (int i = 0; i < CHECKPOINT_COLUMNS; i++) begin
                r_state[i]     <= w_state_next[i];
                r_rob_index[i] <= w_rob_index_next[i];
            end
            r_head         <= w_head_next;
            r_tail         <= w_tail_next;
            r_active_count <= w_count_next;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_checkpoint_ctrl.sv
// ============================================================================
// Module      : tb_checkpoint_ctrl
// Description : Directed plus random bench for checkpoint_ctrl against an
//               in-order queue model of live checkpoints.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_checkpoint_ctrl;

    localparam int N = 4;

    logic       clk;
    logic       nRST;
    logic       save_req_valid;
    logic [4:0] save_req_ROB_index;
    logic       save_req_ready;
    logic       save_en;
    logic [1:0] save_column;
    logic       resolve_valid;
    logic [1:0] resolve_column;
    logic       resolve_mispredict;
    logic       restore_en;
    logic [1:0] restore_column;
    logic [4:0] restore_ROB_index;
    logic       flush;
    logic [2:0] active_count;

    checkpoint_ctrl dut (
        .CLK                (clk),
        .nRST               (nRST),
        .save_req_valid     (save_req_valid),
        .save_req_ROB_index (save_req_ROB_index),
        .save_req_ready     (save_req_ready),
        .save_en            (save_en),
        .save_column        (save_column),
        .resolve_valid      (resolve_valid),
        .resolve_column     (resolve_column),
        .resolve_mispredict (resolve_mispredict),
        .restore_en         (restore_en),
        .restore_column     (restore_column),
        .restore_ROB_index  (restore_ROB_index),
        .flush              (flush),
        .active_count       (active_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Live checkpoints oldest-first; the tail is implied by head + size.
    typedef struct {
        int col;
        int rob;
        bit resolved;
    } ent_t;

    ent_t q[$];
    int   m_head;
    int   n_cmp;
    int   n_bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input bit rstn, input bit sv, input int rob,
                        input bit rv, input int rc, input bit rm, input bit fl);
        int  k;
        int  tail;
        bit  full;
        bit  act;
        bit  mis;
        bit  ready;
        bit  sen;
        bit  retire;
        int  rob_at;
        @(negedge clk);
        nRST               = rstn;
        save_req_valid     = sv;
        save_req_ROB_index = 5'(rob);
        resolve_valid      = rv;
        resolve_column     = 2'(rc);
        resolve_mispredict = rm;
        flush              = fl;
        #1;
        k = -1;
        rob_at = 0;
        foreach (q[i]) if (q[i].col == rc) k = i;
        tail   = (m_head + q.size()) % N;
        full   = (q.size() == N);
        act    = (k >= 0) && !q[k].resolved;
        if (k >= 0) rob_at = q[k].rob;
        mis    = rv && rm && act && !fl;
        retire = (q.size() > 0) && q[0].resolved;
        ready  = !full;
`ifdef CHECKPOINT_CTRL_RETIRE_BYPASS_EN
        if (full && q[0].resolved) ready = 1'b1;
`endif
        ready  = ready && !fl && !mis;
        sen    = sv && ready;
        if (rstn) begin
            chk("save_req_ready", 32'(save_req_ready), 32'(ready));
            chk("save_en",        32'(save_en),        32'(sen));
            chk("save_column",    32'(save_column),    32'(tail));
            chk("restore_en",     32'(restore_en),     32'(mis));
            if (mis) begin
                chk("restore_column",    32'(restore_column),    32'(rc));
                chk("restore_ROB_index", 32'(restore_ROB_index), 32'(rob_at));
            end
        end
        @(posedge clk);
        if (!rstn || fl) begin
            q.delete();
            m_head = 0;
        end else if (mis) begin
            if (k == 0) q.delete();
            else q = q[0:k-1];
            if (retire) begin
                void'(q.pop_front());
                m_head = (m_head + 1) % N;
            end
        end else begin
            if (rv && !rm && act) q[k].resolved = 1'b1;
            if (retire) begin
                void'(q.pop_front());
                m_head = (m_head + 1) % N;
            end
            if (sen) q.push_back('{col: tail, rob: rob % 32, resolved: 1'b0});
        end
        #1;
        chk("active_count", 32'(active_count), 32'(q.size()));
    endtask

    task automatic idle();
        step(1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        m_head = 0;
        nRST = 1'b0;
        save_req_valid = 1'b0;
        save_req_ROB_index = '0;
        resolve_valid = 1'b0;
        resolve_column = '0;
        resolve_mispredict = 1'b0;
        flush = 1'b0;

        do_reset();
        @(negedge clk);
        nRST = 1'b1;
        #1;
        chk("rst_save_req_ready",    32'(save_req_ready),    32'd1);
        chk("rst_save_column",       32'(save_column),       32'd0);
        chk("rst_save_en",           32'(save_en),           32'd0);
        chk("rst_restore_en",        32'(restore_en),        32'd0);
        chk("rst_restore_column",    32'(restore_column),    32'd0);
        chk("rst_restore_ROB_index", 32'(restore_ROB_index), 32'd0);
        chk("rst_active_count",      32'(active_count),      32'd0);

        // Fill all four columns, then a fifth request must stall.
        step(1, 1, 3, 0, 0, 0, 0);
        step(1, 1, 7, 0, 0, 0, 0);
        step(1, 1, 12, 0, 0, 0, 0);
        step(1, 1, 20, 0, 0, 0, 0);
        chk("full_count", 32'(active_count), 32'd4);
        step(1, 1, 25, 0, 0, 0, 0);

        // Out-of-order correct resolves retire in order.
        step(1, 0, 0, 1, 2, 0, 0);
        step(1, 0, 0, 1, 0, 0, 0);
        idle();
        step(1, 0, 0, 1, 1, 0, 0);
        idle();
        idle();
        chk("save_column_after_retire", 32'(save_column), 32'd0);

        // Mispredict in the middle of a full ring.
        do_reset();
        step(1, 1, 3, 0, 0, 0, 0);
        step(1, 1, 7, 0, 0, 0, 0);
        step(1, 1, 12, 0, 0, 0, 0);
        step(1, 1, 20, 0, 0, 0, 0);
        step(1, 0, 0, 1, 1, 1, 0);
        chk("squash_count", 32'(active_count), 32'd1);
        chk("squash_tail",  32'(save_column),  32'd1);

        // Wrap-around allocation and squash.
        do_reset();
        step(1, 1, 1, 0, 0, 0, 0);
        step(1, 1, 2, 0, 0, 0, 0);
        step(1, 1, 4, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 1, 1, 0, 0);
        step(1, 0, 0, 1, 2, 0, 0);
        idle();
        idle();
        step(1, 1, 30, 0, 0, 0, 0);
        step(1, 1, 31, 0, 0, 0, 0);
        step(1, 0, 0, 1, 3, 1, 0);
        chk("wrap_tail", 32'(save_column), 32'd3);

        // Save blocked by mispredict, then by flush.
        step(1, 1, 5, 0, 0, 0, 0);
        step(1, 1, 6, 0, 0, 0, 0);
        step(1, 1, 9, 1, 0, 1, 0);
        step(1, 1, 10, 0, 0, 0, 0);
        step(1, 1, 11, 1, 0, 1, 1);
        chk("flush_tail", 32'(save_column), 32'd0);

        // Full ring with a resolved head column.
        do_reset();
        step(1, 1, 3, 0, 0, 0, 0);
        step(1, 1, 7, 0, 0, 0, 0);
        step(1, 1, 12, 0, 0, 0, 0);
        step(1, 1, 20, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0, 0);
        step(1, 1, 9, 0, 0, 0, 0);
        idle();

        for (int n = 0; n < 500; n++) begin
            step(($urandom_range(0, 99) != 0),
                 ($urandom_range(0, 1) == 1),
                 int'($urandom_range(0, 31)),
                 ($urandom_range(0, 9) < 4),
                 int'($urandom_range(0, N - 1)),
                 ($urandom_range(0, 9) < 3),
                 ($urandom_range(0, 39) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
